// File: rtl/shift_seq_ctrl.sv
// Multicycle sequencer for the shift datapath: drives the shift-amount/source
// selects and the RegDesloc op through LOAD, SHIFT and WRITE, then pulses done.
module shift_seq_ctrl #(
  parameter int SETTLE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] shift_kind,
  output logic       busy,
  output logic [1:0] ShiftAmtControl,
  output logic       ShiftSrc,
  output logic [2:0] ShiftOp,
  output logic       shift_we,
  output logic       done,
  output logic       err
);

  if ((SETTLE < 0) || (SETTLE > 7)) begin : g_bad_settle
    $error("shift_seq_ctrl: SETTLE must be within 0..7");
  end

  localparam logic [2:0] SETTLE_C = 3'(SETTLE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [2:0] K_SRL   = 3'b001;
  localparam logic [2:0] K_SRA   = 3'b010;
  localparam logic [2:0] K_SLLV  = 3'b011;
  localparam logic [2:0] K_SRAV  = 3'b100;
  localparam logic [2:0] K_SLL16 = 3'b101;

  logic [2:0] state_q, state_d;
  logic [2:0] kind_q, kind_d;
  logic [2:0] cnt_q, cnt_d;

  logic       busy_q, busy_d;
  logic [1:0] amt_q, amt_d;
  logic       src_q, src_d;
  logic [2:0] op_q, op_d;
  logic       we_q, we_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  function automatic logic [1:0] amt_sel(input logic [2:0] kind);
    case (kind)
      K_SLLV, K_SRAV: amt_sel = 2'b10;
      K_SLL16:        amt_sel = 2'b01;
      default:        amt_sel = 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] shift_op(input logic [2:0] kind);
    case (kind)
      K_SRL:        shift_op = 3'b011;
      K_SRA, K_SRAV: shift_op = 3'b100;
      default:      shift_op = 3'b010;
    endcase
  endfunction

  // Next-state logic; kind is latched only on an accepted legal start.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = 3'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (shift_kind[2:1] == 2'b11) begin
            state_d = S_ERR;
          end else begin
            state_d = S_LOAD;
            kind_d  = shift_kind;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: begin
        if (cnt_q == SETTLE_C) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_SHIFT;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registers line up with it.
  always_comb begin
    busy_d = 1'b0;
    amt_d  = 2'b00;
    src_d  = 1'b0;
    op_d   = 3'b000;
    we_d   = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_d)
      S_LOAD: begin
        busy_d = 1'b1;
        amt_d  = amt_sel(kind_d);
        src_d  = (kind_d == K_SLL16);
        op_d   = 3'b001;
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        amt_d  = amt_sel(kind_d);
        src_d  = (kind_d == K_SLL16);
        op_d   = shift_op(kind_d);
      end
      S_WRITE: begin
        busy_d = 1'b1;
        amt_d  = amt_sel(kind_d);
        src_d  = (kind_d == K_SLL16);
        we_d   = 1'b1;
        done_d = 1'b1;
      end
      S_ERR: begin
        busy_d = 1'b1;
        err_d  = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= 3'b000;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      amt_q   <= 2'b00;
      src_q   <= 1'b0;
      op_q    <= 3'b000;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      amt_q   <= amt_d;
      src_q   <= src_d;
      op_q    <= op_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy            = busy_q;
  assign ShiftAmtControl = amt_q;
  assign ShiftSrc        = src_q;
  assign ShiftOp         = op_q;
  assign shift_we        = we_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl; three instances cover SETTLE = 0, 2 and 3.
// Observed outputs are packed {busy, amt[1:0], src, op[2:0], we, done, err}.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] shift_kind;

  logic       busy0, busy2, busy3;
  logic [1:0] amt0, amt2, amt3;
  logic       src0, src2, src3;
  logic [2:0] op0, op2, op3;
  logic       we0, we2, we3;
  logic       done0, done2, done3;
  logic       err0, err2, err3;

  logic [9:0] obs0, obs2, obs3;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.SETTLE(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .shift_kind(shift_kind),
    .busy(busy0), .ShiftAmtControl(amt0), .ShiftSrc(src0), .ShiftOp(op0),
    .shift_we(we0), .done(done0), .err(err0)
  );
  shift_seq_ctrl #(.SETTLE(2)) u2 (
    .clk(clk), .reset(reset), .start(start), .shift_kind(shift_kind),
    .busy(busy2), .ShiftAmtControl(amt2), .ShiftSrc(src2), .ShiftOp(op2),
    .shift_we(we2), .done(done2), .err(err2)
  );
  shift_seq_ctrl #(.SETTLE(3)) u3 (
    .clk(clk), .reset(reset), .start(start), .shift_kind(shift_kind),
    .busy(busy3), .ShiftAmtControl(amt3), .ShiftSrc(src3), .ShiftOp(op3),
    .shift_we(we3), .done(done3), .err(err3)
  );

  assign obs0 = {busy0, amt0, src0, op0, we0, done0, err0};
  assign obs2 = {busy2, amt2, src2, op2, we2, done2, err2};
  assign obs3 = {busy3, amt3, src3, op3, we3, done3, err3};

  function automatic logic [9:0] v(input logic b, input logic [1:0] a, input logic s,
                                   input logic [2:0] o, input logic w, input logic d,
                                   input logic e);
    v = {b, a, s, o, w, d, e};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    shift_kind = 3'b000;
    #1;
    checks++;
    if ({obs0, obs2, obs3} !== 30'd0) begin
      $display("FAIL reset_async got %b %b %b exp all zero", obs0, obs2, obs3);
      errors++;
    end
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if ({obs0, obs2, obs3} !== 30'd0) begin
      $display("FAIL reset_idle got %b %b %b exp all zero", obs0, obs2, obs3);
      errors++;
    end
  endtask

  task automatic test_sll();
    logic [9:0] exp_v [4];
    int busy_cnt = 0;
    exp_v[0] = v(1'b1, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    exp_v[1] = v(1'b1, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
    exp_v[2] = v(1'b1, 2'b00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    exp_v[3] = 10'd0;
    shift_kind = 3'b000;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      start = 1'b0;
      if (busy0) busy_cnt++;
      checks++;
      if (obs0 !== exp_v[i]) begin
        $display("FAIL sll cycle %0d got %b exp %b", i + 1, obs0, exp_v[i]);
        errors++;
      end
    end
    checks++;
    if (busy_cnt !== 3) begin
      $display("FAIL sll_busy_cycles got %0d exp 3", busy_cnt);
      errors++;
    end
  endtask

  task automatic test_sll16();
    logic [9:0] exp_v [6];
    exp_v[0] = v(1'b1, 2'b01, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
    exp_v[1] = v(1'b1, 2'b01, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    exp_v[2] = exp_v[1];
    exp_v[3] = exp_v[1];
    exp_v[4] = v(1'b1, 2'b01, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0);
    exp_v[5] = 10'd0;
    shift_kind = 3'b101;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      start = 1'b0;
      checks++;
      if (obs2 !== exp_v[i]) begin
        $display("FAIL sll16 cycle %0d got %b exp %b", i + 1, obs2, exp_v[i]);
        errors++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_v [9];
    exp_v[0] = v(1'b1, 2'b10, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    exp_v[1] = v(1'b1, 2'b10, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
    exp_v[2] = v(1'b1, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    exp_v[3] = 10'd0;
    exp_v[4] = v(1'b1, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    exp_v[5] = v(1'b1, 2'b00, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0);
    exp_v[6] = v(1'b1, 2'b00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    exp_v[7] = 10'd0;
    exp_v[8] = 10'd0;
    shift_kind = 3'b100;
    start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (obs0 !== exp_v[i]) begin
        $display("FAIL back_to_back cycle %0d got %b exp %b", i + 1, obs0, exp_v[i]);
        errors++;
      end
      if (i == 0) shift_kind = 3'b111;
      if (i == 2) shift_kind = 3'b001;
      if (i == 4) start = 1'b0;
    end
  endtask

  task automatic test_illegal();
    logic [9:0] exp_v [3];
    exp_v[0] = v(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    exp_v[1] = 10'd0;
    exp_v[2] = 10'd0;
    shift_kind = 3'b111;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      start = 1'b0;
      checks++;
      if (obs0 !== exp_v[i]) begin
        $display("FAIL illegal cycle %0d got %b exp %b", i + 1, obs0, exp_v[i]);
        errors++;
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [9:0] exp_v [6];
    int dones = 0;
    exp_v[0] = v(1'b1, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    exp_v[1] = v(1'b1, 2'b00, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0);
    exp_v[2] = v(1'b1, 2'b00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    exp_v[3] = 10'd0;
    exp_v[4] = 10'd0;
    exp_v[5] = 10'd0;
    shift_kind = 3'b001;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done0) dones++;
      checks++;
      if (obs0 !== exp_v[i]) begin
        $display("FAIL busy_start cycle %0d got %b exp %b", i + 1, obs0, exp_v[i]);
        errors++;
      end
      if (i == 1) start = 1'b0;
      if (i == 2) start = 1'b1;
      if (i == 3) start = 1'b0;
    end
    checks++;
    if (dones !== 1) begin
      $display("FAIL busy_start_done_count got %0d exp 1", dones);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] exp_v [7];
    int stray = 0;
    shift_kind = 3'b000;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if (obs3 !== v(1'b1, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0)) begin
      $display("FAIL reset_mid_preshift got %b exp 1000010000", obs3);
      errors++;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs3 !== 10'd0) begin
      $display("FAIL reset_mid_async got %b exp 0000000000", obs3);
      errors++;
    end
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (obs3 !== 10'd0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      $display("FAIL reset_mid_quiet got %0d active cycles exp 0", stray);
      errors++;
    end
    exp_v[0] = v(1'b1, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    exp_v[1] = v(1'b1, 2'b00, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
    exp_v[2] = exp_v[1];
    exp_v[3] = exp_v[1];
    exp_v[4] = exp_v[1];
    exp_v[5] = v(1'b1, 2'b00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    exp_v[6] = 10'd0;
    shift_kind = 3'b010;
    start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      start = 1'b0;
      checks++;
      if (obs3 !== exp_v[i]) begin
        $display("FAIL reset_mid_restart cycle %0d got %b exp %b", i + 1, obs3, exp_v[i]);
        errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sll();
    idle(10);
    test_sll16();
    idle(10);
    test_back_to_back();
    idle(10);
    test_illegal();
    idle(10);
    test_start_while_busy();
    idle(10);
    test_reset_mid();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multicycle sequencer for the shift datapath: the shift-amount select mux, the shift-source mux, and the RegDesloc barrel shifter.
- Accepts a decoded shift request from the main control unit and drives the load, shift and write-back steps in order.
- Returns a done pulse to the main control unit when the sequence ends.
- Owns ShiftAmtControl, so the main FSM never drives the shift mux selects directly.

Parameters:
- SETTLE, 0: extra wait cycles held in SHIFT before write-back (0..7), for timing margin on the shifter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs to reset values
- start  in  1  one-cycle request pulse from main control; sampled only in IDLE
- shift_kind  in  3  000 SLL, 001 SRL, 010 SRA, 011 SLLV, 100 SRAV, 101 SLL16 (LUI path); 110/111 illegal
- busy  out  1  high in every state except IDLE
- ShiftAmtControl  out  2  00 OFFSET[10:6] (shamt), 01 constant 16, 10 register operand
- ShiftSrc  out  1  0 selects register B as shift input, 1 selects the immediate
- ShiftOp  out  3  RegDesloc op: 000 hold, 001 load, 010 left, 011 right logical, 100 right arithmetic
- shift_we  out  1  write-back enable for shifter result to register bank, one cycle
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on illegal shift_kind

Behaviour:
- Reset values: busy=0, ShiftAmtControl=00, ShiftSrc=0, ShiftOp=000, shift_we=0, done=0, err=0. Internal kind register=000, settle counter=0.
- All outputs are registered Moore outputs decoded from the state and the latched kind.
- States:
  - IDLE → LOAD: on start with a legal kind. shift_kind is latched on the same edge.
  - IDLE → ERR: on start with kind 110 or 111.
  - LOAD → SHIFT: always, after one cycle.
  - SHIFT → WRITE: when the settle counter equals SETTLE. The counter clears on entry to SHIFT and increments each cycle while in SHIFT.
  - WRITE → IDLE: always, after one cycle.
  - ERR → IDLE: always, after one cycle.
- LOAD outputs:
  - ShiftOp=001.
  - ShiftSrc=1 for SLL16, otherwise 0.
  - ShiftAmtControl per kind: SLL/SRL/SRA → 00; SLLV/SRAV → 10; SLL16 → 01.
- SHIFT outputs:
  - ShiftOp per kind: SLL/SLLV/SLL16 → 010; SRL → 011; SRA/SRAV → 100.
  - ShiftAmtControl and ShiftSrc hold their LOAD values.
- WRITE outputs: ShiftOp=000, shift_we=1, done=1. Amount and source selects stay held so the write sees a stable result.
- ERR outputs: err=1, no shifter activity (ShiftOp=000), shift_we=0, done=0.
- On return to IDLE, ShiftAmtControl, ShiftSrc and ShiftOp return to reset values.
- Latency: the first done occurs SETTLE+3 cycles after the start edge. With SETTLE=0, state goes start → LOAD → SHIFT → WRITE, and done is seen in cycle 3 after start.
- Boundary conditions:
  - start while busy: ignored and not queued. shift_kind changes while busy have no effect.
  - start held high for several cycles: one sequence per return to IDLE. A still-high start in the cycle after WRITE/ERR launches a new sequence; back-to-back is allowed.
  - Zero shift amount: no special path; the full sequence runs and the shifter returns the loaded value.
  - reset mid-sequence: immediate return to IDLE with reset outputs. A pending shift_we or done is never emitted, and the counter clears.
  - done and err are never high in the same cycle. shift_we is high only in WRITE.
  - SETTLE outside 0..7: elaboration error, required.

Test Plan:
- SLL, SETTLE=0: start=1 with kind=000 for one cycle → ShiftOp 001 (ShiftAmtControl=00), then 010, then 000 with shift_we=1 and done=1 on cycle 3. busy is high for exactly 3 cycles.
- SLL16 (LUI), SETTLE=2: kind=101 → ShiftSrc=1, ShiftAmtControl=01 through LOAD, SHIFT and WRITE. SHIFT lasts 3 cycles and done arrives on cycle 5 after start.
- SRAV then SRL back-to-back, with start held high: first sequence uses ShiftAmtControl=10 and ShiftOp=100. The second starts the cycle after done, with 00/011. shift_kind changes during the first sequence do not alter it.
- Illegal kind=111 → err=1 for one cycle, ShiftOp stays 000, no shift_we, no done, back in IDLE the next cycle.
- Reset asserted while in SHIFT (SETTLE=3) → outputs go to reset values immediately without waiting for a clock. No done or shift_we appears afterwards. A new start after reset deassertion sequences normally.
- start pulsed during LOAD and during WRITE → ignored; exactly one done per accepted start.
